xbar_rr_matrix: RTL and testbench
=================================

Name: xbar_rr_matrix

Overview:
- Parametrised NUM_M x NUM_S request/acknowledge crossbar; successor to the fixed 2x2 combinational switch matrix.
- Each slave port has a registered round-robin arbiter with grant lock, so several masters can contend for one slave.
- Slave is decoded from address MSBs.
- Sits between the core-side master ports and the memory/peripheral slave ports.

Parameters:
- NUM_M, 2, number of master ports (2..8)
- NUM_S, 2, number of slave ports (power of two, 2..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_W, $clog2(NUM_S), slave-select field width (derived, localparam)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- m_req  in  NUM_M  per-master request
- m_we  in  NUM_M  per-master write enable (1 = write)
- m_addr  in  NUM_M*ADDR_W  packed master addresses, master i at [i*ADDR_W +: ADDR_W]
- m_wdata  in  NUM_M*DATA_W  packed master write data
- m_ack  out  NUM_M  per-master acknowledge
- m_rdata  out  NUM_M*DATA_W  packed read data to masters
- s_req  out  NUM_S  per-slave request
- s_we  out  NUM_S  per-slave write enable
- s_addr  out  NUM_S*ADDR_W  packed slave addresses; full address forwarded
- s_wdata  out  NUM_S*DATA_W  packed slave write data
- s_ack  in  NUM_S  per-slave acknowledge
- s_rdata  in  NUM_S*DATA_W  packed slave read data

Behaviour:
- Decode: master i targets slave addr[ADDR_W-1 -: SEL_W].
- Master protocol: hold req, we, addr and wdata stable until the ack cycle. Ack is a one-cycle pulse. Req may stay high for a back-to-back transfer.
- Per-slave FSM, IDLE:
  - Candidates are masters with m_req=1 whose address decodes to this slave.
  - Round-robin search starts at last_grant+1 mod NUM_M.
  - If any candidate exists, register grant_idx and go to BUSY.
  - No slave outputs are asserted in IDLE.
- Per-slave FSM, BUSY:
  - s_req/we/addr/wdata are driven combinationally from master grant_idx.
  - When s_ack=1: m_ack[grant_idx]=1 and m_rdata slice = s_rdata in the same cycle. last_grant <= grant_idx. Go to IDLE.
- Latency: 1 arbitration cycle plus the slave's ack latency. Minimum is 2 cycles from req to ack with a zero-wait slave.
- No grant in the same cycle as release; this bubble is intentional.
- Abandon: if m_req[grant_idx] drops in BUSY without s_ack, s_req deasserts that cycle and the FSM returns to IDLE. last_grant is unchanged.
- s_ack while in IDLE is ignored.
- A master is granted by at most one slave, because its address selects exactly one.
- Independent slaves serve different masters concurrently.
- Unselected m_ack bits are 0. m_rdata of a non-acked master is 0.
- Reset: all FSMs IDLE, grant_idx=0, last_grant=NUM_M-1 (so master 0 wins first), all outputs 0.
- rst asserted mid-BUSY aborts the transfer with no ack; outputs are 0 from the next edge.

Optional Feature:
- Macro: XBAR_RESP_REG_EN.
- Defined:
  - m_ack and m_rdata are registered, so the master sees ack one cycle after s_ack.
  - The slave FSM passes through a RESP state (s_req=0) before IDLE.
  - Minimum latency becomes 3.
  - Reset clears the response registers.
- Undefined: response path is combinational as above.

Decomposition:
- Package/header xbar_pkg holds:
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, RESP=2'd2
  - SEL_W derivation function
  - max-size limits
- Sub-module rr_arbiter (parameter N): inputs req vector, last_grant, enable; outputs grant_valid, grant_idx.
- xbar_rr_matrix instantiates one rr_arbiter per slave in a generate loop, plus the slave FSMs and muxes.

Test Plan:
- Single read, NUM_M=2, NUM_S=2, zero-wait slaves: m0 reads addr 0x0000_0010, s0 acks in cycle 1 with rdata 0xDEAD_BEEF → m_ack[0] in cycle 1 after grant (2 cycles after req), m_rdata0=0xDEAD_BEEF, s_req[1] never set.
- Contention: m0 and m1 both write to slave 1 (addr 0x8000_0000) from reset → m0 served first, m1 second. The next simultaneous pair is served m1 first? No: after m1, search starts at m0, so m0, m1, m0 … alternate, with no master starved.
- Parallel: m0 → slave 0 and m1 → slave 1 in the same cycle → both acked in the same cycle, no bubble between them.
- Wait states: slave holds s_ack low 3 cycles → s_req and s_addr stay stable 3 cycles, m_ack single pulse, other master to same slave waits.
- Abandon and reset: m0 drops req during BUSY → s_req low the next cycle, no ack; rst pulsed mid-transfer → all outputs 0, m0 wins the next contention.
- XBAR_RESP_REG_EN defined: single zero-wait read → ack 3 cycles after req, rdata matches.

Source files
------------

// File: rtl/xbar_pkg.sv
// Shared definitions for the round-robin request/acknowledge crossbar.
// Latency: none (types, limits and elaboration-time helpers only).
// Backpressure: not applicable.
package xbar_pkg;

  // Per-slave FSM states. RESP is only reached when XBAR_RESP_REG_EN is defined.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } xbar_state_e;

  // Supported size limits.
  localparam int XBAR_MAX_M = 8;
  localparam int XBAR_MAX_S = 8;

  // Width of an index that selects one of n ports; never narrower than 1 bit.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from last_grant+1 (mod N).
// Latency: combinational; the caller registers the grant.
// Backpressure: no grant while enable is low, so the owner holds it off while busy.
//
// Ports:
//   req         N-bit request vector
//   last_grant  index granted most recently; the search starts just after it
//   enable      permits a grant this cycle
//   grant_valid at least one request seen while enabled
//   grant_idx   winning index (0 when grant_valid is low)
module rr_arbiter #(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  always_comb begin
    int cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (enable) begin
      // k = N wraps back to last_grant itself, so a lone requester that just
      // won is still granted again.
      for (int k = 1; k <= N; k++) begin
        cand = int'(last_grant) + k;
        if (cand >= N) begin
          cand = cand - N;
        end
        if (!grant_valid && req[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/xbar_rr_matrix.sv
// NUM_M x NUM_S req/ack crossbar; each slave port owns a registered round-robin arbiter with grant lock.
// Latency: 1 arbitration cycle + slave ack latency (min 2 cycles req->ack; 3 with XBAR_RESP_REG_EN).
// Backpressure: a master holds req/we/addr/wdata until its ack pulse; losers simply stay pending.
//
// Ports (master i / slave j slices are [i*W +: W]):
//   clk, rst          rising-edge clock, synchronous active-high reset
//   m_req/m_we        per-master request and write enable
//   m_addr/m_wdata    packed master address and write data
//   m_ack/m_rdata     per-master ack pulse and read data (0 unless acked)
//   s_req/s_we        per-slave request and write enable
//   s_addr/s_wdata    packed slave address (full address) and write data
//   s_ack/s_rdata     per-slave ack and read data
// Optional macro XBAR_RESP_REG_EN: registers m_ack/m_rdata and adds a RESP state per slave.
module xbar_rr_matrix
  import xbar_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_M-1:0]           m_req,
  input  logic [NUM_M-1:0]           m_we,
  input  logic [NUM_M*ADDR_W-1:0]    m_addr,
  input  logic [NUM_M*DATA_W-1:0]    m_wdata,
  output logic [NUM_M-1:0]           m_ack,
  output logic [NUM_M*DATA_W-1:0]    m_rdata,
  output logic [NUM_S-1:0]           s_req,
  output logic [NUM_S-1:0]           s_we,
  output logic [NUM_S*ADDR_W-1:0]    s_addr,
  output logic [NUM_S*DATA_W-1:0]    s_wdata,
  input  logic [NUM_S-1:0]           s_ack,
  input  logic [NUM_S*DATA_W-1:0]    s_rdata
);

  localparam int SEL_W = sel_w(NUM_S);
  localparam int IDX_W = sel_w(NUM_M);

  // Slave index each master is addressing (address MSBs).
  logic [SEL_W-1:0] m_sel [NUM_M];

  always_comb begin
    for (int m = 0; m < NUM_M; m++) begin
      m_sel[m] = m_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W];
    end
  end

  // Per-slave ack vectors towards the masters, slave j at [j*NUM_M +: NUM_M].
  logic [NUM_S*NUM_M-1:0] slv_ack;

  for (genvar s = 0; s < NUM_S; s++) begin : g_slv
    xbar_state_e         state_q, state_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [NUM_M-1:0]    cand;
    logic [NUM_M-1:0]    ack_vec;
    logic                arb_en;
    logic                arb_vld;
    logic [IDX_W-1:0]    arb_idx;
    logic                req_o;
    logic                we_o;
    logic [ADDR_W-1:0]   addr_o;
    logic [DATA_W-1:0]   wdata_o;

    always_comb begin
      for (int m = 0; m < NUM_M; m++) begin
        cand[m] = m_req[m] && (m_sel[m] == SEL_W'(s));
      end
    end

    // Arbitration only in IDLE: this locks the grant for the whole transfer
    // and leaves a one-cycle bubble after every release.
    assign arb_en = (state_q == IDLE);

    rr_arbiter #(.N(NUM_M)) u_arb (
      .req         (cand),
      .last_grant  (last_q),
      .enable      (arb_en),
      .grant_valid (arb_vld),
      .grant_idx   (arb_idx)
    );

    always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      req_o   = 1'b0;
      we_o    = 1'b0;
      addr_o  = '0;
      wdata_o = '0;
      ack_vec = '0;
      case (state_q)
        IDLE: begin
          if (arb_vld) begin
            grant_d = arb_idx;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (!m_req[grant_q]) begin
            // Master abandoned: drop the slave request now; rotation unchanged.
            state_d = IDLE;
          end else begin
            req_o   = 1'b1;
            we_o    = m_we[grant_q];
            addr_o  = m_addr[int'(grant_q)*ADDR_W +: ADDR_W];
            wdata_o = m_wdata[int'(grant_q)*DATA_W +: DATA_W];
            if (s_ack[s]) begin
              ack_vec[grant_q] = 1'b1;
              last_d           = grant_q;
`ifdef XBAR_RESP_REG_EN
              state_d = RESP;
`else
              state_d = IDLE;
`endif
            end
          end
        end
        RESP: begin
          // Registered ack is visible to the master this cycle; slave idle.
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        grant_q <= '0;
        last_q  <= IDX_W'(NUM_M - 1);
      end else begin
        state_q <= state_d;
        grant_q <= grant_d;
        last_q  <= last_d;
      end
    end

    assign s_req[s]                     = req_o;
    assign s_we[s]                      = we_o;
    assign s_addr[s*ADDR_W +: ADDR_W]   = addr_o;
    assign s_wdata[s*DATA_W +: DATA_W]  = wdata_o;
    assign slv_ack[s*NUM_M +: NUM_M]    = ack_vec;
  end

  // Merge slave responses per master. A master's address selects exactly one
  // slave, so at most one term is non-zero and OR-ing is safe.
  logic [NUM_M-1:0]        m_ack_d;
  logic [NUM_M*DATA_W-1:0] m_rdata_d;

  always_comb begin
    m_ack_d   = '0;
    m_rdata_d = '0;
    for (int m = 0; m < NUM_M; m++) begin
      for (int s = 0; s < NUM_S; s++) begin
        if (slv_ack[s*NUM_M + m]) begin
          m_ack_d[m]                    = 1'b1;
          m_rdata_d[m*DATA_W +: DATA_W] = m_rdata_d[m*DATA_W +: DATA_W]
                                        | s_rdata[s*DATA_W +: DATA_W];
        end
      end
    end
  end

`ifdef XBAR_RESP_REG_EN
  logic [NUM_M-1:0]        m_ack_q;
  logic [NUM_M*DATA_W-1:0] m_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ack_q   <= '0;
      m_rdata_q <= '0;
    end else begin
      m_ack_q   <= m_ack_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_ack   = m_ack_q;
  assign m_rdata = m_rdata_q;
`else
  assign m_ack   = m_ack_d;
  assign m_rdata = m_rdata_d;
`endif

endmodule

// File: tb/tb_xbar_rr_matrix.sv
// Directed self-checking bench for xbar_rr_matrix (2 masters x 2 slaves).
// Latency: expectations adapt to XBAR_RESP_REG_EN (ack 2 or 3 edges after req).
// Backpressure: slave model inserts a programmable number of wait cycles per slave.
module tb_xbar_rr_matrix;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int AW = 32;
  localparam int DW = 32;

`ifdef XBAR_RESP_REG_EN
  localparam int LAT = 3;   // edges from req assertion to the edge the master sees ack
  localparam int PER = 3;   // spacing of back-to-back grants on one slave
`else
  localparam int LAT = 2;
  localparam int PER = 2;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NM-1:0]        m_req;
  logic [NM-1:0]        m_we;
  logic [NM*AW-1:0]     m_addr;
  logic [NM*DW-1:0]     m_wdata;
  logic [NM-1:0]        m_ack;
  logic [NM*DW-1:0]     m_rdata;
  logic [NS-1:0]        s_req;
  logic [NS-1:0]        s_we;
  logic [NS*AW-1:0]     s_addr;
  logic [NS*DW-1:0]     s_wdata;
  logic [NS-1:0]        s_ack;
  logic [NS*DW-1:0]     s_rdata;

  always #5 clk = ~clk;

  xbar_rr_matrix #(.NUM_M(NM), .NUM_S(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_ack   (m_ack),
    .m_rdata (m_rdata),
    .s_req   (s_req),
    .s_we    (s_we),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_ack   (s_ack),
    .s_rdata (s_rdata)
  );

  // Slave model: ack once the request has been held for wait_cfg cycles.
  int          wait_cfg [NS];
  logic [DW-1:0] rdat_cfg [NS];
  int          wcnt [NS];

  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      if (s_req[s] && !s_ack[s]) wcnt[s] <= wcnt[s] + 1;
      else                       wcnt[s] <= 0;
    end
  end

  always_comb begin
    for (int s = 0; s < NS; s++) begin
      s_ack[s]             = s_req[s] && (wcnt[s] >= wait_cfg[s]);
      s_rdata[s*DW +: DW]  = rdat_cfg[s];
    end
  end

  // Running totals of ack pulses and slave-1 request cycles.
  int ack_tot [NM];
  int s1_tot;

  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (m_ack[m]) ack_tot[m] <= ack_tot[m] + 1;
    end
    if (s_req[1]) s1_tot <= s1_tot + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    m_req[m]            = req;
    m_we[m]             = we;
    m_addr[m*AW +: AW]  = addr;
    m_wdata[m*DW +: DW] = wd;
  endtask

  task automatic do_reset;
    rst   = 1'b1;
    m_req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called right after driving requests (cycle 0). Returns at the negedge of
  // the first cycle showing any ack; who = -1 if none within the budget.
  task automatic wait_any(output int who, output int lat, output logic [DW-1:0] rd);
    who = -1;
    lat = -1;
    rd  = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_ack != '0) begin
        for (int m = NM - 1; m >= 0; m--) begin
          if (m_ack[m]) who = m;
        end
        lat = c + 1;
        rd  = m_rdata[who*DW +: DW];
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int who, lat, base0, base1, sbase;
    logic [DW-1:0] rd;
    int seq_m[$];
    int seq_c[$];

    for (int s = 0; s < NS; s++) begin
      wait_cfg[s] = 0;
      rdat_cfg[s] = '0;
    end
    m_we = '0; m_addr = '0; m_wdata = '0;

    // Reset state
    do_reset;
    rst = 1'b1;
    @(negedge clk);
    check("rst_m_ack",   m_ack,   '0);
    check("rst_m_rdata", m_rdata, '0);
    check("rst_s_req",   s_req,   '0);
    check("rst_s_addr",  s_addr,  '0);
    next_cycle;
    rst = 1'b0;

    // Single read, zero-wait slave 0
    do_reset;
    rdat_cfg[0] = 32'hDEAD_BEEF;
    sbase = s1_tot;
    set_m(0, 1'b1, 1'b0, 32'h0000_0010, '0);
    wait_any(who, lat, rd);
    check("t1_who",    who, 0);
    check("t1_lat",    lat, LAT);
    check("t1_rdata",  rd,  32'hDEAD_BEEF);
    check("t1_ackvec", m_ack, 2'b01);
    check("t1_rdata1", m_rdata[DW +: DW], '0);
    next_cycle;
    m_req = '0;
    repeat (2) next_cycle;
    check("t1_s1_quiet", s1_tot - sbase, 0);

    // Contention: both masters write slave 1 back-to-back
    do_reset;
    rdat_cfg[1] = 32'h1111_2222;
    set_m(0, 1'b1, 1'b1, 32'h8000_0000, 32'hA0A0_0000);
    set_m(1, 1'b1, 1'b1, 32'h8000_0004, 32'hB1B1_0001);
    for (int c = 0; c < LAT + 4*PER; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("t2_sreq",  s_req, 2'b10);
        check("t2_swe",   s_we[1], 1'b1);
        check("t2_saddr", s_addr[AW +: AW], 32'h8000_0000);
        check("t2_swd",   s_wdata[DW +: DW], 32'hA0A0_0000);
      end
      for (int m = 0; m < NM; m++) begin
        if (m_ack[m]) begin
          seq_m.push_back(m);
          seq_c.push_back(c);
        end
      end
      @(posedge clk);
      #1;
    end
    m_req = '0;
    check("t2_count_ok", seq_m.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i < seq_m.size()) begin
        check($sformatf("t2_order%0d", i), seq_m[i], i % 2);
        check($sformatf("t2_cycle%0d", i), seq_c[i], LAT - 1 + i*PER);
      end
    end

    // Parallel: independent slaves ack in the same cycle
    do_reset;
    rdat_cfg[0] = 32'h0000_AAAA;
    rdat_cfg[1] = 32'h0000_BBBB;
    set_m(0, 1'b1, 1'b0, 32'h0000_0020, '0);
    set_m(1, 1'b1, 1'b0, 32'h8000_0040, '0);
    for (int c = 0; c < LAT; c++) begin
      @(negedge clk);
      if (c == 1)       check("t3_sreq", s_req, 2'b11);
      if (c == LAT - 2) check("t3_pre",  m_ack, 2'b00);
      if (c == LAT - 1) begin
        check("t3_ack",    m_ack, 2'b11);
        check("t3_rdata0", m_rdata[0 +: DW], 32'h0000_AAAA);
        check("t3_rdata1", m_rdata[DW +: DW], 32'h0000_BBBB);
      end
      if (c < LAT - 1) next_cycle;
    end
    next_cycle;
    m_req = '0;

    // Wait states: slave 1 holds ack low 3 cycles, m1 queued behind m0
    do_reset;
    wait_cfg[1] = 3;
    rdat_cfg[1] = 32'hCAFE_F00D;
    base0 = ack_tot[0];
    set_m(0, 1'b1, 1'b0, 32'h8000_0100, '0);
    set_m(1, 1'b1, 1'b0, 32'h8000_0200, '0);
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        check($sformatf("t4_sreq%0d", c),  s_req[1], 1'b1);
        check($sformatf("t4_saddr%0d", c), s_addr[AW +: AW], 32'h8000_0100);
        check($sformatf("t4_noack%0d", c), m_ack, 2'b00);
      end
      if (c == LAT + 2) begin
        check("t4_ack",   m_ack, 2'b01);
        check("t4_rdata", m_rdata[0 +: DW], 32'hCAFE_F00D);
      end
      if (c < LAT + 2) next_cycle;
    end
    next_cycle;
    m_req[0] = 1'b0;
    wait_any(who, lat, rd);
    check("t4_m1_who", who, 1);
    check("t4_m1_lat", lat, LAT + 3);
    next_cycle;
    m_req = '0;
    check("t4_m0_pulses", ack_tot[0] - base0, 1);
    wait_cfg[1] = 0;

    // Abandon: m0 drops req while slave 0 is waiting
    do_reset;
    wait_cfg[0] = 3;
    base0 = ack_tot[0];
    set_m(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    next_cycle;
    @(negedge clk);
    check("t5_busy", s_req, 2'b01);
    next_cycle;
    m_req[0] = 1'b0;
    @(negedge clk);
    check("t5_sreq_drop", s_req, 2'b00);
    check("t5_noack",     m_ack, 2'b00);
    repeat (4) next_cycle;
    check("t5_no_pulse", ack_tot[0] - base0, 0);
    // Rotation untouched by the abandon: m0 still wins
    wait_cfg[0] = 0;
    set_m(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    set_m(1, 1'b1, 1'b0, 32'h0000_0044, '0);
    wait_any(who, lat, rd);
    check("t5_m0_first", who, 0);
    next_cycle;
    m_req = '0;
    repeat (3) next_cycle;

    // Reset mid-transfer: m1 in BUSY on slave 0 (last grant currently m0)
    wait_cfg[0] = 3;
    base1 = ack_tot[1];
    set_m(1, 1'b1, 1'b0, 32'h0000_0048, '0);
    next_cycle;
    @(negedge clk);
    check("t6_busy", s_req, 2'b01);
    next_cycle;
    rst = 1'b1;
    next_cycle;
    @(negedge clk);
    check("t6_rst_sreq",   s_req,   2'b00);
    check("t6_rst_ack",    m_ack,   2'b00);
    check("t6_rst_rdata",  m_rdata, '0);
    next_cycle;
    rst = 1'b0;
    wait_cfg[0] = 0;
    set_m(0, 1'b1, 1'b0, 32'h0000_0040, '0);
    wait_any(who, lat, rd);
    check("t6_m0_wins",   who, 0);
    check("t6_m1_no_ack", ack_tot[1] - base1, 0);
    next_cycle;
    m_req = '0;
    repeat (2) next_cycle;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
